branch_pred_unit: RTL and testbench
===================================

BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of BTB/BHT entries; power of two, 16..1024.
REQ-002 SHALL have parameter CNT_W, default 2, BHT saturating-counter width; 1..4.
REQ-003 SHALL have parameter GHR_W, default 6, global history width; 1..log2(ENTRIES); used only under BP_GSHARE_EN.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port if_valid, input, 1, fetch lookup request.
REQ-007 SHALL have port if_pc, input, 32, fetch PC for the lookup.
REQ-008 SHALL have port if_allowin, input, 1, fetch accepts a new PC; 0 means stall.
REQ-009 SHALL have port flush, input, 1, discard the in-flight prediction.
REQ-010 SHALL have port pred_valid, output, 1, prediction outputs valid.
REQ-011 SHALL have port pred_pc, output, 32, PC the prediction belongs to.
REQ-012 SHALL have port pred_taken, output, 1, predicted taken.
REQ-013 SHALL have port pred_target, output, 32, predicted next PC.
REQ-014 SHALL have port upd_valid, input, 1, resolved-branch update strobe from issue stage.
REQ-015 SHALL have port upd_pc, input, 32, resolved branch PC.
REQ-016 SHALL have port upd_taken, input, 1, resolved direction.
REQ-017 SHALL have port upd_target, input, 32, resolved taken target.

Function
REQ-018 SHALL compute index = upd_pc/if_pc[IDX+1:2], IDX = log2(ENTRIES); tag = pc[31:IDX+2].
REQ-019 SHALL register lookup results: one-cycle latency from accepted request (if_valid & if_allowin) to pred_* outputs.
REQ-020 SHALL hold all pred_* outputs unchanged while if_allowin=0 and flush=0.
REQ-021 SHALL drive pred_valid=0 in the cycle after flush=1; flush overrides a simultaneous accepted request.
REQ-022 SHALL drive pred_valid=0 in the cycle after if_valid=0 with if_allowin=1.
REQ-023 SHALL declare hit when BTB entry valid and stored tag equals lookup tag.
REQ-024 SHALL set pred_taken = hit & counter MSB; pred_target = pred_taken ? stored target : pred_pc+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
REQ-025 SHALL on upd_valid increment the indexed counter if upd_taken, else decrement; saturate at 2^CNT_W-1 and at 0.
REQ-026 SHALL on upd_valid & upd_taken write BTB entry {valid=1, tag, upd_target}, overwriting any alias.
REQ-027 SHALL on upd_valid & ~upd_taken leave the BTB entry unchanged.
REQ-028 SHALL give lookup read-before-write semantics: a same-cycle update to the same index is not visible to that lookup, visible to the next.

Reset
REQ-029 SHALL on reset=1 asynchronously clear all BTB valid bits, set every counter to 2^(CNT_W-1)-1 (weakly not-taken), clear GHR, drive pred_valid=0, pred_taken=0, pred_pc=0, pred_target=0.
REQ-030 SHALL discard any lookup or update in progress when reset asserts mid-operation; first lookup accepted after deassertion is served normally.

Configuration
REQ-031 SHALL, with BP_GSHARE_EN defined, index the BHT with pc index XOR {zero-extend, GHR}, and shift upd_taken into GHR LSB on every upd_valid; BTB remains PC-indexed.
REQ-032 SHALL, without BP_GSHARE_EN, index BHT by PC only, and contain no GHR logic.

Structure
REQ-033 SHALL place default ENTRIES/CNT_W/GHR_W constants, weak-not-taken init value and the pred/update bus widths in shared package bp_pkg.
REQ-034 SHALL instantiate one sub-module bp_sat_counter (parameter CNT_W; inputs cur, inc, en; output next) for counter arithmetic.

Verification
REQ-035 SHALL verify: after reset, lookup pc=0x1C000000 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x1C000004.
REQ-036 SHALL verify: two updates pc=0x1C000010 taken target 0x1C000100 (CNT_W=2) -> lookup gives pred_taken=1, pred_target=0x1C000100; two not-taken updates -> pred_taken=0.
REQ-037 SHALL verify: 5 taken updates on CNT_W=2 then 1 not-taken -> counter 2, still predicts taken (saturation at 3).
REQ-038 SHALL verify: update and lookup same pc same cycle -> lookup returns pre-update result; repeat next cycle -> updated result.
REQ-039 SHALL verify: if_allowin=0 for 3 cycles -> pred_* stable; flush with accepted request -> pred_valid=0 next cycle.
REQ-040 SHALL verify: reset asserted mid-stream after taken updates -> pred_* zero immediately, post-reset lookup of same pc predicts not-taken; with BP_GSHARE_EN, identical PCs with differing GHR map to distinct counters.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and bundle types for the branch prediction unit.
// BP_GSHARE_EN selects gshare BHT indexing; default build is PC-indexed.
package bp_pkg;

  localparam int ENTRIES_DEF = 64;
  localparam int CNT_W_DEF   = 2;
  localparam int GHR_W_DEF   = 6;
  localparam int PC_W        = 32;
  localparam int PRED_W      = 2 * PC_W + 2;
  localparam int UPD_W       = 2 * PC_W + 2;

  function automatic logic [3:0] wnt_init(input int cnt_w);
    return 4'((1 << (cnt_w - 1)) - 1);
  endfunction

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } pred_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } upd_t;

endpackage

// File: rtl/branch_pred_unit_if.sv
// Fetch lookup, prediction and resolved-branch update signals.
// master = fetch/issue side, slave = predictor.
interface branch_pred_unit_if;
  import bp_pkg::*;

  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic            if_allowin;
  logic            flush;
  logic            pred_valid;
  logic [PC_W-1:0] pred_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;

  modport master (
    output if_valid, if_pc, if_allowin, flush,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_valid, pred_pc, pred_taken, pred_target
  );

  modport slave (
    input  if_valid, if_pc, if_allowin, flush,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output pred_valid, pred_pc, pred_taken, pred_target
  );

endinterface

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter step used by the BHT.
// next = cur when en is low.
module bp_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cur,
  input  logic             inc,
  input  logic             en,
  output logic [CNT_W-1:0] next
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] MIN = '0;

  always_comb begin
    next = cur;
    if (en) begin
      if (inc && cur != MAX)
        next = cur + 1'b1;
      else if (!inc && cur != MIN)
        next = cur - 1'b1;
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// BTB + BHT branch predictor with registered one-cycle lookup.
// Define BP_GSHARE_EN to XOR global history into the BHT index.
module branch_pred_unit
  import bp_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GHR_W   = GHR_W_DEF
) (
  input logic clk,
  input logic reset,
  branch_pred_unit_if.slave bp
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX - 2;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(wnt_init(CNT_W));

  logic [ENTRIES-1:0] btb_vld;
  logic [TAG_W-1:0]   btb_tag [ENTRIES];
  logic [PC_W-1:0]    btb_tgt [ENTRIES];
  logic [CNT_W-1:0]   bht     [ENTRIES];

  logic [IDX-1:0]   l_idx;
  logic [IDX-1:0]   u_idx;
  logic [IDX-1:0]   l_bidx;
  logic [IDX-1:0]   u_bidx;
  logic [TAG_W-1:0] l_tag;
  logic [TAG_W-1:0] u_tag;

  assign l_idx = bp.if_pc[IDX+1:2];
  assign u_idx = bp.upd_pc[IDX+1:2];
  assign l_tag = bp.if_pc[PC_W-1:IDX+2];
  assign u_tag = bp.upd_pc[PC_W-1:IDX+2];

  logic unused_bits;
  assign unused_bits = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign l_bidx = l_idx ^ IDX'(ghr);
  assign u_bidx = u_idx ^ IDX'(ghr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ghr <= '0;
    else if (bp.upd_valid)
      ghr <= GHR_W'({ghr, bp.upd_taken});
  end
`else
  localparam int unused_ghr_w = GHR_W;

  assign l_bidx = l_idx;
  assign u_bidx = u_idx;
`endif

  logic [CNT_W-1:0] cnt_next;

  bp_sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .cur (bht[u_bidx]),
    .inc (bp.upd_taken),
    .en  (bp.upd_valid),
    .next(cnt_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        bht[i] <= CNT_INIT;
    end else if (bp.upd_valid) begin
      bht[u_bidx] <= cnt_next;
    end
  end

  logic btb_wr;
  assign btb_wr = bp.upd_valid & bp.upd_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      btb_vld <= '0;
    else if (btb_wr)
      btb_vld[u_idx] <= 1'b1;
  end

  // Payload is qualified by btb_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[u_idx] <= u_tag;
      btb_tgt[u_idx] <= bp.upd_target;
    end
  end

  logic            l_hit;
  logic            l_taken;
  logic [PC_W-1:0] l_target;

  always_comb begin
    l_hit    = btb_vld[l_idx] && (btb_tag[l_idx] == l_tag);
    l_taken  = l_hit && bht[l_bidx][CNT_W-1];
    l_target = l_taken ? btb_tgt[l_idx]
                       : bp.if_pc + 32'd4;
  end

  pred_t pred_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_q <= '0;
    end else if (bp.flush) begin
      pred_q.valid <= 1'b0;
    end else if (bp.if_allowin) begin
      pred_q.valid <= bp.if_valid;
      if (bp.if_valid) begin
        pred_q.pc     <= bp.if_pc;
        pred_q.taken  <= l_taken;
        pred_q.target <= l_target;
      end
    end
  end

  assign bp.pred_valid  = pred_q.valid;
  assign bp.pred_pc     = pred_q.pc;
  assign bp.pred_taken  = pred_q.taken;
  assign bp.pred_target = pred_q.target;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Randomized bench for branch_pred_unit against a table-level model.
// Also pins the model with hand-computed directed cases.
module tb_branch_pred_unit;

  localparam int ENT  = 64;
  localparam int CMAX = 3;
  localparam int WEAK = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  branch_pred_unit_if bp_bus ();

  branch_pred_unit dut (
    .clk  (clk),
    .reset(reset),
    .bp   (bp_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: tables indexed by (pc/4) mod ENT, counters as plain ints.
  bit          m_vld [ENT];
  int unsigned m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_cnt [ENT];
  int unsigned m_ghr = 0;

  logic        e_valid  = 0;
  logic        e_taken  = 0;
  logic [31:0] e_pc     = 0;
  logic [31:0] e_target = 0;

  int  li, bi, ui, ub;
  bit  hit, tk;

  function automatic int slot(input logic [31:0] pc);
    return int'(pc >> 2) % ENT;
  endfunction

  function automatic int hslot(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return slot(pc) ^ int'(m_ghr % ENT);
`else
    return slot(pc);
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENT; i++) begin
        m_vld[i] = 0;
        m_cnt[i] = WEAK;
      end
      m_ghr    = 0;
      e_valid  = 0;
      e_taken  = 0;
      e_pc     = 0;
      e_target = 0;
    end else begin
      li = slot(bp_bus.if_pc);
      bi = hslot(bp_bus.if_pc);
      ui = slot(bp_bus.upd_pc);
      ub = hslot(bp_bus.upd_pc);
      if (bp_bus.flush) begin
        e_valid = 0;
      end else if (bp_bus.if_allowin) begin
        e_valid = bp_bus.if_valid;
        if (bp_bus.if_valid) begin
          hit = m_vld[li] &&
                m_tag[li] == (bp_bus.if_pc >> (2 + 6));
          tk  = hit && m_cnt[bi] >= (CMAX + 1) / 2;
          e_pc     = bp_bus.if_pc;
          e_taken  = tk;
          e_target = tk ? m_tgt[li] : bp_bus.if_pc + 32'd4;
        end
      end
      if (bp_bus.upd_valid) begin
        if (bp_bus.upd_taken) begin
          if (m_cnt[ub] < CMAX) m_cnt[ub]++;
          m_vld[ui] = 1;
          m_tag[ui] = bp_bus.upd_pc >> (2 + 6);
          m_tgt[ui] = bp_bus.upd_target;
        end else begin
          if (m_cnt[ub] > 0) m_cnt[ub]--;
        end
        m_ghr = ((m_ghr << 1) | 32'(bp_bus.upd_taken)) % 64;
      end
    end
  end

  always @(negedge clk) begin
    chk("pred_valid",  32'(bp_bus.pred_valid), 32'(e_valid));
    chk("pred_pc",     bp_bus.pred_pc, e_pc);
    chk("pred_taken",  32'(bp_bus.pred_taken), 32'(e_taken));
    chk("pred_target", bp_bus.pred_target, e_target);
  end

  task automatic idle();
    bp_bus.if_valid   = 0;
    bp_bus.if_pc      = 0;
    bp_bus.if_allowin = 1;
    bp_bus.flush      = 0;
    bp_bus.upd_valid  = 0;
    bp_bus.upd_pc     = 0;
    bp_bus.upd_taken  = 0;
    bp_bus.upd_target = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic tk,
                     input logic [31:0] tgt);
    bp_bus.upd_valid  = 1;
    bp_bus.upd_pc     = pc;
    bp_bus.upd_taken  = tk;
    bp_bus.upd_target = tgt;
    step();
    bp_bus.upd_valid  = 0;
  endtask

  task automatic look(input logic [31:0] pc);
    bp_bus.if_valid = 1;
    bp_bus.if_pc    = pc;
    step();
    bp_bus.if_valid = 0;
  endtask

  task automatic chk_pred(input string nm,
                          input logic v,
                          input logic t,
                          input logic [31:0] tgt);
    chk({nm, ".valid"},  32'(bp_bus.pred_valid), 32'(v));
    chk({nm, ".taken"},  32'(bp_bus.pred_taken), 32'(t));
    chk({nm, ".target"}, bp_bus.pred_target, tgt);
  endtask

  task automatic chk_zero(input string nm);
    chk_pred(nm, 0, 0, 32'h0);
    chk({nm, ".pc"}, bp_bus.pred_pc, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk_zero("rst_async");
    step();
    step();
    reset = 0;
    step();
  endtask

  initial begin
    idle();
    #1;
    do_reset();
    chk_zero("rst_idle");

    look(32'hFFFF_FFFC);
    chk_pred("wrap", 1, 0, 32'h0000_0000);

    look(32'h1C00_0000);
    chk_pred("first_lookup", 1, 0, 32'h1C00_0004);
    chk("first_lookup.pc", bp_bus.pred_pc, 32'h1C00_0000);

    step();
    chk("idle_drop", 32'(bp_bus.pred_valid), 32'h0);

`ifndef BP_GSHARE_EN
    upd(32'h1C00_0010, 1, 32'h1C00_0100);
    upd(32'h1C00_0010, 1, 32'h1C00_0100);
    look(32'h1C00_0010);
    chk_pred("train_taken", 1, 1, 32'h1C00_0100);
    upd(32'h1C00_0010, 0, 32'h0);
    upd(32'h1C00_0010, 0, 32'h0);
    look(32'h1C00_0010);
    chk_pred("train_nt", 1, 0, 32'h1C00_0014);

    for (int i = 0; i < 5; i++)
      upd(32'h1C00_0020, 1, 32'h1C00_0300);
    upd(32'h1C00_0020, 0, 32'h0);
    look(32'h1C00_0020);
    chk_pred("saturate", 1, 1, 32'h1C00_0300);

    bp_bus.upd_valid  = 1;
    bp_bus.upd_pc     = 32'h1C00_0030;
    bp_bus.upd_taken  = 1;
    bp_bus.upd_target = 32'h1C00_0200;
    look(32'h1C00_0030);
    bp_bus.upd_valid  = 0;
    chk_pred("rbw_old", 1, 0, 32'h1C00_0034);
    look(32'h1C00_0030);
    chk_pred("rbw_new", 1, 1, 32'h1C00_0200);

    look(32'h1C00_0020);
    bp_bus.if_allowin = 0;
    bp_bus.if_valid   = 1;
    bp_bus.if_pc      = 32'h1C00_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_pred("stall", 1, 1, 32'h1C00_0300);
      chk("stall.pc", bp_bus.pred_pc, 32'h1C00_0020);
    end
    bp_bus.if_allowin = 1;
    bp_bus.flush      = 1;
    step();
    chk("flush", 32'(bp_bus.pred_valid), 32'h0);
    idle();
    step();
`else
    upd(32'h1C00_0010, 1, 32'h1C00_0100);
    look(32'h1C00_0010);
    chk_pred("gshare_ghr", 1, 0, 32'h1C00_0014);
`endif

    for (int n = 0; n < 3000; n++) begin
      bp_bus.if_valid   = $urandom_range(0, 3) != 0;
      bp_bus.if_pc      = 32'h1C00_0000 +
                          ($urandom_range(0, 1) << 8) +
                          ($urandom_range(0, 7) << 2);
      bp_bus.if_allowin = $urandom_range(0, 4) != 0;
      bp_bus.flush      = $urandom_range(0, 9) == 0;
      bp_bus.upd_valid  = $urandom_range(0, 1);
      bp_bus.upd_pc     = 32'h1C00_0000 +
                          ($urandom_range(0, 1) << 8) +
                          ($urandom_range(0, 7) << 2);
      bp_bus.upd_taken  = $urandom_range(0, 2) != 0;
      bp_bus.upd_target = $urandom & 32'hFFFF_FFFC;
      if (n == 1500) bp_bus.if_pc = 32'hFFFF_FFFC;
      step();
    end

    idle();
    upd(32'h1C00_0040, 1, 32'h1C00_0400);
    upd(32'h1C00_0040, 1, 32'h1C00_0400);
    look(32'h1C00_0040);
`ifndef BP_GSHARE_EN
    chk_pred("pre_rst", 1, 1, 32'h1C00_0400);
`endif
    do_reset();
    look(32'h1C00_0040);
    chk_pred("post_rst", 1, 0, 32'h1C00_0044);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
